sr_cmd_sequencer: RTL and testbench
===================================

// Module: sr_cmd_sequencer
// PURPOSE
//  Upstream driver for the NOR SR latch stage. Takes raw, asynchronous set/reset
//  requests (push-buttons or other-domain strobes) and synchronises and debounces them.
//  Emits clean, mutually exclusive, fixed-width set/reset pulses into the latch.
//  Never drives the latch's forbidden set=1/reset=1 input combination.
// PARAMETERS
//  DEBOUNCE_CYCLES  8  stable cycles required before a raw level change is accepted (>=2)
//  PULSE_CYCLES     4  width of each set_o/reset_o pulse in clk cycles (>=1)
//  HOLDOFF_CYCLES   2  cycles with both outputs low after every pulse (>=1)
// PORTS
//  clk        in   1  system clock, rising edge
//  rst_n      in   1  asynchronous active-low reset
//  set_raw    in   1  raw set request, asynchronous, may bounce
//  reset_raw  in   1  raw reset request, asynchronous, may bounce
//  set_o      out  1  clean set pulse to latch
//  reset_o    out  1  clean reset pulse to latch
//  busy       out  1  high while a pulse or holdoff is in progress
//  q_track    out  1  modelled latch state: 1 after a set pulse, 0 after a reset pulse
//  conflict   out  1  sticky simultaneous-request flag (present only with SR_CONFLICT_FLAG_EN)
// BEHAVIOUR
//  - Reset (rst_n=0, async): all sync/debounce flops, pending flags and counters are 0.
//    set_o=0, reset_o=0, busy=0, q_track=0, conflict=0, FSM=IDLE.
//  - Sync: 2-flop synchroniser per input.
//  - Debounce: per channel, a stable level and a counter. The counter clears whenever the
//    synced value equals stable. Otherwise it increments. When it reaches
//    DEBOUNCE_CYCLES-1 while still differing, stable flips. Glitches shorter than
//    DEBOUNCE_CYCLES are ignored.
//  - Request: a 0->1 edge of a stable level sets that channel's pending flag. Pending holds
//    until the FSM accepts it. A repeat edge while pending is absorbed; no queueing beyond 1.
//    Falling edges are ignored.
//  - FSM states: IDLE, SET_P, RST_P, HOLD.
//    IDLE: reset_pend -> RST_P (reset has priority). Otherwise set_pend -> SET_P.
//    Both pending in the same cycle -> RST_P, and set_pend is also cleared.
//    On accept, the accepted pending flag(s) clear and the pulse counter loads.
//    SET_P/RST_P: the output is high for exactly PULSE_CYCLES cycles, then -> HOLD.
//    HOLD: both outputs are low for exactly HOLDOFF_CYCLES cycles, then -> IDLE.
//  - Outputs are registered. set_o and reset_o are never high in the same cycle, in any state.
//  - q_track updates on the first cycle of a pulse: 1 for SET_P, 0 for RST_P.
//  - busy = (state != IDLE).
//  - Latency: with the FSM idle and a clean input, set_o/reset_o first go high
//    3+DEBOUNCE_CYCLES edges after the first edge that samples raw high.
//  - Requests arriving while busy stay pending and are serviced on the IDLE cycle after HOLD.
//    Reset still beats set at that point.
//  - rst_n asserted mid-pulse: outputs drop immediately (async). Pending requests are discarded.
// CONFIGURATION
//  - SR_CONFLICT_FLAG_EN defined: port conflict exists.
//    It sets to 1 on any IDLE accept where both pending flags were 1.
//    It is sticky and clears only on rst_n.
//  - SR_CONFLICT_FLAG_EN undefined: port conflict and its flop are absent.
//    All other behaviour is identical.
// STRUCTURE
//  - Package sr_seq_pkg: state enum typedef (IDLE/SET_P/RST_P/HOLD) and a clog2-based
//    counter-width function.
//    Counter widths are derived localparams from DEBOUNCE/PULSE/HOLDOFF.
//  - Sub-module sr_debounce (sync + debounce + rising-edge detect), instantiated once per
//    channel.
//  - The top level holds the pending flags, FSM, counters and output registers.
// TESTING (DEBOUNCE_CYCLES=4, PULSE_CYCLES=3, HOLDOFF_CYCLES=2)
//  1. Reset: rst_n=0 for 3 cycles with raw inputs toggling -> all outputs 0 throughout.
//  2. Clean set: set_raw=1 held 20 cycles -> set_o high for exactly 3 cycles starting
//     7 edges after the first sampling edge. busy high for 5 cycles. q_track=1. reset_o stays 0.
//  3. Bounce: set_raw pulsed 1 for 2 cycles, 5 times with 1-cycle gaps -> no set_o pulse.
//     A final 6-cycle hold -> exactly one 3-cycle set_o pulse.
//  4. Simultaneous: set_raw and reset_raw rise on the same edge -> one reset_o pulse only,
//     q_track=0. conflict=1 with SR_CONFLICT_FLAG_EN, port absent without it.
//  5. Busy queueing: reset_raw edge debounced during a set pulse -> reset_o rises on the
//     edge after HOLD ends. Never overlaps set_o.
//  6. Reset mid-pulse: rst_n low during cycle 2 of set_o -> set_o=0 asynchronously.
//     After release, no pulse until a new raw edge.
//  - All scenarios: assertion !(set_o && reset_o) checked every cycle.

Source files
------------

// File: rtl/sr_seq_pkg.sv
// Shared state encoding and counter sizing helpers for the SR latch command sequencer.
package sr_seq_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SET_P = 2'd1;
    localparam logic [1:0] ST_RST_P = 2'd2;
    localparam logic [1:0] ST_HOLD  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        SET_P = ST_SET_P,
        RST_P = ST_RST_P,
        HOLD  = ST_HOLD
    } sr_state_e;

    // Bits needed to hold the values 0 .. n-1 (never less than one bit).
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sr_cmd_sequencer_if.sv
// Request/pulse bundle between the raw request sources and the sequencer.
// The conflict flag exists only when SR_CONFLICT_FLAG_EN is defined.
interface sr_cmd_sequencer_if;
    logic set_raw;
    logic reset_raw;
    logic set_o;
    logic reset_o;
    logic busy;
    logic q_track;
`ifdef SR_CONFLICT_FLAG_EN
    logic conflict;
`endif

    modport master (
        output set_raw, reset_raw,
        input  set_o, reset_o, busy, q_track
`ifdef SR_CONFLICT_FLAG_EN
        , input conflict
`endif
    );

    modport slave (
        input  set_raw, reset_raw,
        output set_o, reset_o, busy, q_track
`ifdef SR_CONFLICT_FLAG_EN
        , output conflict
`endif
    );
endinterface

// File: rtl/sr_debounce.sv
// Two-flop synchroniser, counter debouncer and registered rising-edge strobe for one
// raw request line.
module sr_debounce
    import sr_seq_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_i,
    output logic rise_o
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES);

    logic          sync1_q;
    logic          sync2_q;
    logic          stable_q;
    logic          stable_d;
    logic          rise_q;
    logic          rise_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Accept a new level only after it has differed from the stable one long enough.
    always_comb begin
        stable_d = stable_q;
        rise_d   = 1'b0;
        cnt_d    = '0;
        if (sync2_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
            stable_d = ~stable_q;
            rise_d   = ~stable_q;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Synchroniser and debounce state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            rise_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= raw_i;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            rise_q   <= rise_d;
            cnt_q    <= cnt_d;
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/sr_cmd_sequencer.sv
// Turns debounced set/reset requests into exclusive fixed-width pulses for a NOR SR latch.
// Optional sticky conflict flag: define SR_CONFLICT_FLAG_EN.
module sr_cmd_sequencer
    import sr_seq_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 8,
    parameter int PULSE_CYCLES    = 4,
    parameter int HOLDOFF_CYCLES  = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    sr_cmd_sequencer_if.slave   bus
);

    localparam int CW = cnt_width(max_int(PULSE_CYCLES, HOLDOFF_CYCLES));

    logic          set_rise_s;
    logic          rst_rise_s;
    logic          set_pend_q, set_pend_d;
    logic          rst_pend_q, rst_pend_d;
    sr_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          set_q, set_d;
    logic          reset_q, reset_d;
    logic          busy_q, busy_d;
    logic          q_track_q, q_track_d;

    sr_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_set (
        .clk    (clk),
        .rst_n  (rst_n),
        .raw_i  (bus.set_raw),
        .rise_o (set_rise_s)
    );

    sr_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_rst (
        .clk    (clk),
        .rst_n  (rst_n),
        .raw_i  (bus.reset_raw),
        .rise_o (rst_rise_s)
    );

    // Pulse/holdoff sequencing; reset wins and swallows a simultaneous set request.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        set_pend_d = set_pend_q;
        rst_pend_d = rst_pend_q;
        q_track_d  = q_track_q;
        case (state_q)
            IDLE: begin
                if (rst_pend_q) begin
                    state_d    = RST_P;
                    cnt_d      = CW'(PULSE_CYCLES - 1);
                    rst_pend_d = 1'b0;
                    set_pend_d = 1'b0;
                    q_track_d  = 1'b0;
                end else if (set_pend_q) begin
                    state_d    = SET_P;
                    cnt_d      = CW'(PULSE_CYCLES - 1);
                    set_pend_d = 1'b0;
                    q_track_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            SET_P, RST_P: begin
                if (cnt_q == '0) begin
                    state_d = HOLD;
                    cnt_d   = CW'(HOLDOFF_CYCLES - 1);
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            HOLD: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        set_pend_d = set_pend_d | set_rise_s;
        rst_pend_d = rst_pend_d | rst_rise_s;
        set_d      = (state_d == SET_P);
        reset_d    = (state_d == RST_P);
        busy_d     = (state_d != IDLE);
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            set_pend_q <= 1'b0;
            rst_pend_q <= 1'b0;
            set_q      <= 1'b0;
            reset_q    <= 1'b0;
            busy_q     <= 1'b0;
            q_track_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            set_pend_q <= set_pend_d;
            rst_pend_q <= rst_pend_d;
            set_q      <= set_d;
            reset_q    <= reset_d;
            busy_q     <= busy_d;
            q_track_q  <= q_track_d;
        end
    end

    assign bus.set_o   = set_q;
    assign bus.reset_o = reset_q;
    assign bus.busy    = busy_q;
    assign bus.q_track = q_track_q;

`ifdef SR_CONFLICT_FLAG_EN
    logic conflict_q;

    // Sticky record of an accept that found both requests pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conflict_q <= 1'b0;
        end else begin
            conflict_q <= conflict_q | ((state_q == IDLE) & set_pend_q & rst_pend_q);
        end
    end

    assign bus.conflict = conflict_q;
`endif

endmodule

// File: tb/tb_sr_cmd_sequencer.sv
// Directed bench for sr_cmd_sequencer with DEBOUNCE=4, PULSE=3, HOLDOFF=2.
module tb_sr_cmd_sequencer;

    localparam int DEB  = 4;
    localparam int PUL  = 3;
    localparam int HOFF = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    sr_cmd_sequencer_if bus_if ();

    sr_cmd_sequencer #(
        .DEBOUNCE_CYCLES (DEB),
        .PULSE_CYCLES    (PUL),
        .HOLDOFF_CYCLES  (HOFF)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    int n_pass  = 0;
    int n_total = 0;

    int   set_rises  = 0;
    int   rst_rises  = 0;
    int   set_cycles = 0;
    int   rst_cycles = 0;
    int   excl_viol  = 0;
    int   rst_viol   = 0;
    logic set_prev   = 1'b0;
    logic rst_prev   = 1'b0;

    // Mid-cycle monitor: pulse edges/widths, exclusivity, quiet outputs during reset.
    always @(negedge clk) begin
        if (bus_if.set_o && bus_if.reset_o) excl_viol <= excl_viol + 1;
        if (!rst_n && (bus_if.set_o || bus_if.reset_o || bus_if.busy || bus_if.q_track))
            rst_viol <= rst_viol + 1;
        if (bus_if.set_o && !set_prev)   set_rises <= set_rises + 1;
        if (bus_if.reset_o && !rst_prev) rst_rises <= rst_rises + 1;
        set_cycles <= set_cycles + (bus_if.set_o ? 1 : 0);
        rst_cycles <= rst_cycles + (bus_if.reset_o ? 1 : 0);
        set_prev   <= bus_if.set_o;
        rst_prev   <= bus_if.reset_o;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_total++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int b_sr, b_rr, b_sc, b_rc;

    initial begin
        bus_if.set_raw   = 1'b0;
        bus_if.reset_raw = 1'b0;

        // 1: reset with raw inputs toggling
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            bus_if.set_raw   = i[0];
            bus_if.reset_raw = ~i[0];
        end
        chk("rst_set_o",   int'(bus_if.set_o),   0);
        chk("rst_reset_o", int'(bus_if.reset_o), 0);
        chk("rst_busy",    int'(bus_if.busy),    0);
        chk("rst_q_track", int'(bus_if.q_track), 0);
`ifdef SR_CONFLICT_FLAG_EN
        chk("rst_conflict", int'(bus_if.conflict), 0);
`endif
        bus_if.set_raw   = 1'b0;
        bus_if.reset_raw = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick(10);
        chk("idle_no_pulse", set_rises + rst_rises, 0);

        // 2: clean set, first high 7 edges after the sampling edge
        b_sr = set_rises; b_rr = rst_rises; b_sc = set_cycles;
        bus_if.set_raw = 1'b1;
        tick(7);
        chk("s2_pre_edge7",   int'(bus_if.set_o), 0);
        chk("s2_busy_pre",    int'(bus_if.busy),  0);
        tick(1);
        chk("s2_edge7_set",   int'(bus_if.set_o),   1);
        chk("s2_edge7_busy",  int'(bus_if.busy),    1);
        chk("s2_edge7_q",     int'(bus_if.q_track), 1);
        tick(2);
        chk("s2_edge9_set",   int'(bus_if.set_o), 1);
        tick(1);
        chk("s2_edge10_set",  int'(bus_if.set_o), 0);
        chk("s2_edge10_busy", int'(bus_if.busy),  1);
        tick(1);
        chk("s2_edge11_busy", int'(bus_if.busy),  1);
        tick(1);
        chk("s2_edge12_busy", int'(bus_if.busy),  0);
        tick(8);
        bus_if.set_raw = 1'b0;
        tick(15);
        chk("s2_set_pulses", set_rises - b_sr,  1);
        chk("s2_set_width",  set_cycles - b_sc, PUL);
        chk("s2_no_reset",   rst_rises - b_rr,  0);
        chk("s2_q_track",    int'(bus_if.q_track), 1);
`ifdef SR_CONFLICT_FLAG_EN
        chk("s2_conflict", int'(bus_if.conflict), 0);
`endif

        // 3: bounce rejected, then one long hold accepted
        b_sr = set_rises; b_sc = set_cycles;
        for (int k = 0; k < 5; k++) begin
            bus_if.set_raw = 1'b1;
            tick(2);
            bus_if.set_raw = 1'b0;
            tick(1);
        end
        tick(12);
        chk("s3_bounce_none", set_rises - b_sr, 0);
        bus_if.set_raw = 1'b1;
        tick(6);
        bus_if.set_raw = 1'b0;
        tick(20);
        chk("s3_hold_pulses", set_rises - b_sr,  1);
        chk("s3_hold_width",  set_cycles - b_sc, PUL);

        // 4: simultaneous requests, reset wins
        b_sr = set_rises; b_rr = rst_rises; b_rc = rst_cycles;
        bus_if.set_raw   = 1'b1;
        bus_if.reset_raw = 1'b1;
        tick(8);
        chk("s4_edge7_reset", int'(bus_if.reset_o), 1);
        tick(2);
        bus_if.set_raw   = 1'b0;
        bus_if.reset_raw = 1'b0;
        tick(20);
        chk("s4_reset_pulses", rst_rises - b_rr,  1);
        chk("s4_reset_width",  rst_cycles - b_rc, PUL);
        chk("s4_no_set",       set_rises - b_sr,  0);
        chk("s4_q_track",      int'(bus_if.q_track), 0);
`ifdef SR_CONFLICT_FLAG_EN
        chk("s4_conflict", int'(bus_if.conflict), 1);
`endif

        // 5: reset request debounced during a set pulse waits for holdoff
        b_sr = set_rises; b_rr = rst_rises;
        bus_if.set_raw = 1'b1;
        tick(3);
        bus_if.reset_raw = 1'b1;
        tick(7);
        chk("s5_edge9_set",    int'(bus_if.set_o),   1);
        chk("s5_edge9_reset",  int'(bus_if.reset_o), 0);
        tick(3);
        chk("s5_edge12_busy",  int'(bus_if.busy),    0);
        chk("s5_edge12_reset", int'(bus_if.reset_o), 0);
        tick(1);
        chk("s5_edge13_reset", int'(bus_if.reset_o), 1);
        chk("s5_edge13_set",   int'(bus_if.set_o),   0);
        chk("s5_edge13_q",     int'(bus_if.q_track), 0);
        tick(3);
        chk("s5_edge16_reset", int'(bus_if.reset_o), 0);
        bus_if.set_raw   = 1'b0;
        bus_if.reset_raw = 1'b0;
        tick(20);
        chk("s5_set_pulses",   set_rises - b_sr, 1);
        chk("s5_reset_pulses", rst_rises - b_rr, 1);

        // 6: async reset during second cycle of set pulse
        bus_if.set_raw = 1'b1;
        tick(9);
        chk("s6_cycle2_set", int'(bus_if.set_o), 1);
        #2 rst_n = 1'b0;
        bus_if.set_raw = 1'b0;
        #1;
        chk("s6_async_set",  int'(bus_if.set_o),   0);
        chk("s6_async_busy", int'(bus_if.busy),    0);
        chk("s6_async_q",    int'(bus_if.q_track), 0);
`ifdef SR_CONFLICT_FLAG_EN
        chk("s6_async_conflict", int'(bus_if.conflict), 0);
`endif
        b_sr = set_rises; b_rr = rst_rises;
        tick(2);
        rst_n = 1'b1;
        tick(25);
        chk("s6_no_replay", (set_rises - b_sr) + (rst_rises - b_rr), 0);
        bus_if.set_raw = 1'b1;
        tick(12);
        bus_if.set_raw = 1'b0;
        tick(15);
        chk("s6_new_edge_pulse", set_rises - b_sr, 1);
        chk("s6_new_edge_q",     int'(bus_if.q_track), 1);

        chk("never_both_high",  excl_viol, 0);
        chk("quiet_in_reset",   rst_viol,  0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
